keypad_code_lock: RTL and testbench

KEYPAD_CODE_LOCK -- requirements
Module: keypad_code_lock

---
 rtl/keypad_pkg.sv | 19 +
 rtl/cycle_timer.sv | 42 ++++
 rtl/keypad_code_lock.sv | 234 +++++++++++++++++++++++
 tb/tb_keypad_code_lock.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared constants for the keypad code lock: FSM state encoding and keypad key codes.
// Key codes 0-9 are digits; 14 and 15 carry no function and are ignored everywhere.
package keypad_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_ENTRY   = 3'd0;
  localparam logic [2:0] ST_CHECK   = 3'd1;
  localparam logic [2:0] ST_OPEN    = 3'd2;
  localparam logic [2:0] ST_PROGRAM = 3'd3;
  localparam logic [2:0] ST_LOCKOUT = 3'd4;

  // Function key codes
  localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;
  localparam logic [3:0] KEY_CLEAR     = 4'd10;
  localparam logic [3:0] KEY_ENTER     = 4'd11;
  localparam logic [3:0] KEY_RELOCK    = 4'd12;
  localparam logic [3:0] KEY_PROG      = 4'd13;

endpackage

// File: rtl/cycle_timer.sv
// Free-running cycle counter with restart and a terminal-count pulse.
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset
//   enable  - count while high
//   restart - force count to zero (takes priority over counting)
//   done    - high for the cycle in which the count sits at LIMIT-1 while enabled
// The counter wraps to zero after done, so done repeats every LIMIT enabled cycles.
module cycle_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic restart,
  output logic done
);

  localparam int unsigned W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count_q;

  // done depends only on the registered count so that callers may feed
  // state changes caused by done back into restart without a loop.
  assign done = enable && (count_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (restart) begin
      count_q <= '0;
    end else if (enable) begin
      if (done) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + W'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_code_lock.sv
// Keypad code lock: collects BCD digits from a keypad scanner, checks them against a
// stored code, opens on a match and allows the code to be reprogrammed while open.
// An inactivity timer clears a stale partial entry and relocks an idle open lock.
//
// Optional feature: define CODE_LOCK_LOCKOUT_EN to count consecutive failed checks and
// enter an alarm lockout (all keys ignored) for LOCKOUT_CYC cycles after MAX_FAIL of them.
// Without the macro there is no fail counter, no lockout timer, and alarm is 0.
//
// Ports:
//   clk          - the only clock, rising edge
//   rst          - synchronous active-high reset
//   key_flag     - one-cycle key strobe (back-to-back strobes are distinct keys)
//   key_value    - key code, valid while key_flag is high
//   entry_digits - digits entered so far, right-aligned BCD, newest digit in nibble 0
//   digit_cnt    - number of buffered digits
//   unlocked     - high while the lock is open
//   result_valid - one-cycle pulse when a code check completes
//   result_ok    - check outcome, qualified by result_valid
//   alarm        - high while locked out
module keypad_code_lock
  import keypad_pkg::*;
#(
  parameter int unsigned CODE_LEN     = 4,
  parameter logic [31:0] DEFAULT_CODE = 32'h0000_1234,
  parameter int unsigned TIMEOUT_CYC  = 250_000_000,
  parameter int unsigned MAX_FAIL     = 3,
  parameter int unsigned LOCKOUT_CYC  = 1_500_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_flag,
  input  logic [3:0]            key_value,
  output logic [4*CODE_LEN-1:0] entry_digits,
  output logic [3:0]            digit_cnt,
  output logic                  unlocked,
  output logic                  result_valid,
  output logic                  result_ok,
  output logic                  alarm
);

  localparam int unsigned EW = 4 * CODE_LEN;
  localparam logic [3:0] CNT_FULL = 4'(CODE_LEN);

  if (CODE_LEN < 1 || CODE_LEN > 8 || TIMEOUT_CYC < 2 || MAX_FAIL < 1 ||
      LOCKOUT_CYC < 2) begin : g_param_check
    $error("keypad_code_lock: parameter out of range");
  end

  logic [2:0]    state_q, state_d;
  logic [EW-1:0] code_q, code_d;
  logic [EW-1:0] entry_q, entry_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          result_valid_q, result_valid_d;
  logic          result_ok_q, result_ok_d;

  logic key_digit, key_clear, key_enter, key_relock, key_prog;
  logic code_match;
  logic idle_restart, idle_done;

  assign key_digit  = key_flag && (key_value <= KEY_MAX_DIGIT);
  assign key_clear  = key_flag && (key_value == KEY_CLEAR);
  assign key_enter  = key_flag && (key_value == KEY_ENTER);
  assign key_relock = key_flag && (key_value == KEY_RELOCK);
  assign key_prog   = key_flag && (key_value == KEY_PROG);

  assign code_match = (cnt_q == CNT_FULL) && (entry_q == code_q);

  // Inactivity timer: any key or any state change starts the idle window again.
  assign idle_restart = key_flag || (state_d != state_q);

  cycle_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_idle_timer (
    .clk     (clk),
    .rst     (rst),
    .enable  (1'b1),
    .restart (idle_restart),
    .done    (idle_done)
  );

`ifdef CODE_LOCK_LOCKOUT_EN
  localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);

  logic [FAIL_W-1:0] fail_q, fail_d;
  logic              lock_done;

  cycle_timer #(
    .LIMIT (LOCKOUT_CYC)
  ) u_lock_timer (
    .clk     (clk),
    .rst     (rst),
    .enable  (state_q == ST_LOCKOUT),
    .restart (state_d != state_q),
    .done    (lock_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fail_q <= '0;
    end else begin
      fail_q <= fail_d;
    end
  end

  assign alarm = (state_q == ST_LOCKOUT);
`else
  assign alarm = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    code_d         = code_q;
    entry_d        = entry_q;
    cnt_d          = cnt_q;
    result_valid_d = 1'b0;
    result_ok_d    = 1'b0;
`ifdef CODE_LOCK_LOCKOUT_EN
    fail_d         = fail_q;
`endif

    case (state_q)
      ST_ENTRY, ST_PROGRAM: begin
        if (key_digit) begin
          // Digits past CODE_LEN are dropped so the buffer always holds the first entries.
          if (cnt_q < CNT_FULL) begin
            entry_d = (entry_q << 4) | EW'(key_value);
            cnt_d   = cnt_q + 4'd1;
          end
        end else if (key_clear) begin
          entry_d = '0;
          cnt_d   = '0;
        end else if (key_enter) begin
          if (state_q == ST_ENTRY) begin
            state_d = ST_CHECK;
          end else begin
            if (cnt_q == CNT_FULL) begin
              code_d  = entry_q;
              state_d = ST_OPEN;
            end
            entry_d = '0;
            cnt_d   = '0;
          end
        end else if (key_relock && (state_q == ST_PROGRAM)) begin
          state_d = ST_ENTRY;
          entry_d = '0;
          cnt_d   = '0;
        end else if (!key_flag && idle_done) begin
          if (state_q == ST_PROGRAM) begin
            state_d = ST_ENTRY;
          end
          entry_d = '0;
          cnt_d   = '0;
        end
      end

      ST_CHECK: begin
        // Keys arriving here are dropped; the check uses the buffer as it stood at enter.
        result_valid_d = 1'b1;
        result_ok_d    = code_match;
        entry_d        = '0;
        cnt_d          = '0;
        if (code_match) begin
          state_d = ST_OPEN;
`ifdef CODE_LOCK_LOCKOUT_EN
          fail_d  = '0;
`endif
        end else begin
          state_d = ST_ENTRY;
`ifdef CODE_LOCK_LOCKOUT_EN
          fail_d  = fail_q + FAIL_W'(1);
          if (fail_d == FAIL_W'(MAX_FAIL)) begin
            state_d = ST_LOCKOUT;
          end
`endif
        end
      end

      ST_OPEN: begin
        if (key_clear) begin
          entry_d = '0;
          cnt_d   = '0;
        end else if (key_relock) begin
          state_d = ST_ENTRY;
        end else if (key_prog) begin
          state_d = ST_PROGRAM;
          entry_d = '0;
          cnt_d   = '0;
        end else if (!key_flag && idle_done) begin
          state_d = ST_ENTRY;
        end
      end

`ifdef CODE_LOCK_LOCKOUT_EN
      ST_LOCKOUT: begin
        if (lock_done) begin
          state_d = ST_ENTRY;
          fail_d  = '0;
        end
      end
`endif

      default: begin
        state_d = ST_ENTRY;
        entry_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_ENTRY;
      code_q         <= DEFAULT_CODE[EW-1:0];
      entry_q        <= '0;
      cnt_q          <= '0;
      result_valid_q <= 1'b0;
      result_ok_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      code_q         <= code_d;
      entry_q        <= entry_d;
      cnt_q          <= cnt_d;
      result_valid_q <= result_valid_d;
      result_ok_q    <= result_ok_d;
    end
  end

  assign entry_digits = entry_q;
  assign digit_cnt    = cnt_q;
  assign unlocked     = (state_q == ST_OPEN);
  assign result_valid = result_valid_q;
  assign result_ok    = result_ok_q;

endmodule

// File: tb/tb_keypad_code_lock.sv
// Directed testbench for keypad_code_lock with short timeout and lockout windows.
// Lockout checks are compiled in when CODE_LOCK_LOCKOUT_EN is defined.
module tb_keypad_code_lock;

  localparam int unsigned TO  = 40;
  localparam int unsigned LCK = 20;

  localparam logic [3:0] K_CLR = 4'd10;
  localparam logic [3:0] K_ENT = 4'd11;
  localparam logic [3:0] K_REL = 4'd12;
  localparam logic [3:0] K_PRG = 4'd13;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_flag;
  logic [3:0]  key_value;
  logic [15:0] entry_digits;
  logic [3:0]  digit_cnt;
  logic        unlocked;
  logic        result_valid;
  logic        result_ok;
  logic        alarm;

  int n_assert = 0;
  int n_fail   = 0;

  keypad_code_lock #(
    .CODE_LEN     (4),
    .DEFAULT_CODE (32'h0000_1234),
    .TIMEOUT_CYC  (TO),
    .MAX_FAIL     (3),
    .LOCKOUT_CYC  (LCK)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_flag     (key_flag),
    .key_value    (key_value),
    .entry_digits (entry_digits),
    .digit_cnt    (digit_cnt),
    .unlocked     (unlocked),
    .result_valid (result_valid),
    .result_ok    (result_ok),
    .alarm        (alarm)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of test, expected end before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input logic [3:0] k);
    key_flag  = 1'b1;
    key_value = k;
    tick();
    key_flag  = 1'b0;
    key_value = 4'd0;
  endtask

  // Four digits, most significant first, then enter, then the CHECK cycle.
  // Returns in the cycle where result_valid is expected high.
  task automatic try_code(input logic [15:0] c);
    logic [15:0] v;
    v = c;
    for (int i = 3; i >= 0; i--) press(v[4*i +: 4]);
    press(K_ENT);
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    key_flag  = 1'b0;
    key_value = 4'd0;
    wait_cycles(3);
    rst = 1'b0;

    // Reset state
    chk("rst_entry", 32'(entry_digits), 32'h0);
    chk("rst_cnt", 32'(digit_cnt), 32'd0);
    chk("rst_unlocked", 32'(unlocked), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_ok", 32'(result_ok), 32'd0);
    chk("rst_alarm", 32'(alarm), 32'd0);

    // Digit shifting, overflow digit dropped, back-to-back strobes
    press(4'd1);
    chk("first_digit", 32'(entry_digits), 32'h1);
    chk("first_cnt", 32'(digit_cnt), 32'd1);
    press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    chk("overflow_entry", 32'(entry_digits), 32'h1234);
    chk("overflow_cnt", 32'(digit_cnt), 32'd4);
    press(4'd14); press(4'd15);
    chk("ignored_14_15", 32'(entry_digits), 32'h1234);
    press(K_CLR);
    chk("clear_entry", 32'(entry_digits), 32'h0);
    chk("clear_cnt", 32'(digit_cnt), 32'd0);
    chk("clear_state", 32'(unlocked), 32'd0);

    // Correct code: result two cycles after enter
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    press(K_ENT);
    chk("check_cycle_valid", 32'(result_valid), 32'd0);
    tick();
    chk("ok_valid", 32'(result_valid), 32'd1);
    chk("ok_ok", 32'(result_ok), 32'd1);
    chk("ok_unlocked", 32'(unlocked), 32'd1);
    chk("ok_cnt", 32'(digit_cnt), 32'd0);
    tick();
    chk("ok_valid_pulse", 32'(result_valid), 32'd0);

    // Digits and enter ignored while open
    press(4'd5);
    chk("open_digit_ign", 32'(digit_cnt), 32'd0);
    press(K_ENT);
    tick();
    chk("open_enter_ign", 32'(result_valid), 32'd0);
    chk("open_still", 32'(unlocked), 32'd1);
    press(K_REL);
    chk("relock", 32'(unlocked), 32'd0);

    // Short code fails
    press(4'd1); press(4'd2); press(4'd3);
    press(K_ENT);
    tick();
    chk("short_valid", 32'(result_valid), 32'd1);
    chk("short_ok", 32'(result_ok), 32'd0);
    chk("short_cnt", 32'(digit_cnt), 32'd0);
    chk("short_unlocked", 32'(unlocked), 32'd0);

    try_code(16'h1235);
    chk("wrong_ok", 32'(result_ok), 32'd0);
    try_code(16'h1234);
    chk("reopen_ok", 32'(result_ok), 32'd1);

    // Program a new code
    press(K_PRG);
    chk("prog_unlocked", 32'(unlocked), 32'd0);
    press(4'd9); press(4'd8);
    chk("prog_partial", 32'(entry_digits), 32'h98);
    press(K_ENT);
    chk("prog_short_cnt", 32'(digit_cnt), 32'd0);
    chk("prog_short_stay", 32'(unlocked), 32'd0);
    press(4'd9); press(4'd8); press(4'd7); press(4'd6);
    chk("prog_full", 32'(entry_digits), 32'h9876);
    press(K_ENT);
    chk("prog_store_open", 32'(unlocked), 32'd1);
    chk("prog_no_result", 32'(result_valid), 32'd0);
    press(K_REL);
    try_code(16'h9876);
    chk("new_code_valid", 32'(result_valid), 32'd1);
    chk("new_code_ok", 32'(result_ok), 32'd1);
    press(K_REL);
    try_code(16'h1234);
    chk("old_code_ok", 32'(result_ok), 32'd0);

    // Reset in PROGRAM loses the programmed code
    try_code(16'h9876);
    press(K_PRG);
    press(4'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_cnt", 32'(digit_cnt), 32'd0);
    chk("mid_rst_unlocked", 32'(unlocked), 32'd0);
    try_code(16'h9876);
    chk("lost_code_ok", 32'(result_ok), 32'd0);
    try_code(16'h1234);
    chk("default_back_ok", 32'(result_ok), 32'd1);

    // Idle timeout relocks an open lock
    wait_cycles(TO - 4);
    chk("idle_open_before", 32'(unlocked), 32'd1);
    wait_cycles(6);
    chk("idle_open_after", 32'(unlocked), 32'd0);

    // Idle timeout clears a partial entry
    press(4'd1); press(4'd2);
    wait_cycles(TO - 4);
    chk("idle_entry_before", 32'(digit_cnt), 32'd2);
    wait_cycles(6);
    chk("idle_entry_cnt", 32'(digit_cnt), 32'd0);
    chk("idle_entry_buf", 32'(entry_digits), 32'h0);

    // Three consecutive failures
    try_code(16'h1111);
    try_code(16'h1111);
    try_code(16'h1111);
    chk("third_fail_ok", 32'(result_ok), 32'd0);
`ifdef CODE_LOCK_LOCKOUT_EN
    chk("lockout_alarm", 32'(alarm), 32'd1);
    try_code(16'h1234);
    tick();
    chk("lockout_ign_valid", 32'(result_valid), 32'd0);
    chk("lockout_ign_unlock", 32'(unlocked), 32'd0);
    chk("lockout_ign_cnt", 32'(digit_cnt), 32'd0);
    wait_cycles(LCK - 11);
    chk("lockout_alarm_late", 32'(alarm), 32'd1);
    wait_cycles(4);
    chk("lockout_exit_alarm", 32'(alarm), 32'd0);
`else
    chk("no_lockout_alarm", 32'(alarm), 32'd0);
`endif
    try_code(16'h1234);
    chk("after_fails_ok", 32'(result_ok), 32'd1);
    chk("after_fails_unlk", 32'(unlocked), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
